// File: rtl/fft_pkg.sv
// Shared FFT definitions: frame geometry, complex sample type, loader FSM states
// and a reference bit-reversal helper.
package fft_pkg;

    localparam int LOG2N = 9;
    localparam int N     = 1 << LOG2N;
    localparam int W     = 16;

    typedef struct packed {
        logic signed [W-1:0] re;
        logic signed [W-1:0] im;
    } cplx_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_START,
        ST_WAIT_HI,
        ST_WAIT_LO
    } ld_state_e;

    function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] idx);
        logic [LOG2N-1:0] r;
        r = '0;
        for (int b = 0; b < LOG2N; b++) begin
            r[b] = idx[LOG2N-1-b];
        end
        return r;
    endfunction

endpackage

// File: rtl/bit_reverse.sv
// Combinational bit reversal of a LOG2N-bit sample index.
module bit_reverse #(
    parameter int LOG2N = 9
) (
    input  logic [LOG2N-1:0] i_idx,
    output logic [LOG2N-1:0] o_rev
);

    always_comb begin
        o_rev = '0;
        for (int b = 0; b < LOG2N; b++) begin
            o_rev[b] = i_idx[LOG2N-1-b];
        end
    end

endmodule

// File: rtl/fft_input_loader.sv
// FFT front end: accepts complex samples, pre-scales them and writes them into the
// ping-pong input banks in bit-reversed order, then kicks off the FFT.
//
// state      | meaning
// -----------+--------------------------------------------------------------
// ST_IDLE    | ready, no frame in progress
// ST_LOAD    | ready, counting samples of the current frame
// ST_START   | frame complete, o_start visible for one enabled cycle
// ST_WAIT_HI | waiting for the FFT control to report busy
// ST_WAIT_LO | waiting for the FFT control to go idle again
module fft_input_loader #(
    parameter int LOG2N = fft_pkg::LOG2N,
    parameter int W     = fft_pkg::W,
    parameter int SHIFT = 1
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_en,
    input  logic                 i_valid,
    output logic                 o_ready,
    input  logic [0:1][W-1:0]    i_data,
    input  logic                 i_last,
    output logic [1:0]           o_wr_en,
    output logic [LOG2N-1:0]     o_wr_addr,
    output logic [0:1][W-1:0]    o_wr_data,
    output logic                 o_start,
    input  logic                 i_fft_active,
    output logic                 o_err,
    output logic                 o_busy
);

    import fft_pkg::*;

    localparam logic [LOG2N-1:0] IDX_LAST = '1;

    ld_state_e        state, state_nxt;
    logic [LOG2N-1:0] n_q, n_nxt;
    logic [LOG2N-1:0] rev;
    logic             acc;
    logic             rdy_q;
    logic             wr_q, wr_nxt;
    logic             start_q, start_nxt;
    logic             err_q, err_nxt;
    logic             bank_q;
    logic [LOG2N-1:0] addr_q;
    logic [0:1][W-1:0] data_q;
    logic signed [W-1:0] re_s, im_s;

    bit_reverse #(.LOG2N(LOG2N)) u_bit_reverse (
        .i_idx (n_q),
        .o_rev (rev)
    );

    assign re_s = $signed(i_data[0]) >>> SHIFT;
    assign im_s = $signed(i_data[1]) >>> SHIFT;

    // rdy_q keeps o_ready low while reset is asserted even though state is IDLE
    assign o_ready = rdy_q && ((state == ST_IDLE) || (state == ST_LOAD));
    assign acc     = i_valid && o_ready && i_en;

    always_comb begin
        state_nxt = state;
        n_nxt     = n_q;
        wr_nxt    = 1'b0;
        start_nxt = 1'b0;
        err_nxt   = 1'b0;
        case (state)
            ST_IDLE, ST_LOAD: begin
                if (acc) begin
                    wr_nxt = 1'b1;
                    if (n_q == IDX_LAST) begin
                        state_nxt = ST_START;
                        n_nxt     = '0;
                        start_nxt = 1'b1;
                        err_nxt   = !i_last;
                    end else if (i_last) begin
                        state_nxt = ST_LOAD;
                        n_nxt     = '0;
                        err_nxt   = 1'b1;
                    end else begin
                        state_nxt = ST_LOAD;
                        n_nxt     = n_q + 1'b1;
                    end
                end
            end
            ST_START:   state_nxt = ST_WAIT_HI;
            ST_WAIT_HI: if (i_fft_active)  state_nxt = ST_WAIT_LO;
            ST_WAIT_LO: if (!i_fft_active) state_nxt = ST_IDLE;
            default:    state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state   <= ST_IDLE;
            n_q     <= '0;
            rdy_q   <= 1'b0;
            wr_q    <= 1'b0;
            start_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            rdy_q <= 1'b1;
            if (i_en) begin
                state   <= state_nxt;
                n_q     <= n_nxt;
                wr_q    <= wr_nxt;
                start_q <= start_nxt;
                err_q   <= err_nxt;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            bank_q <= 1'b0;
            addr_q <= '0;
            data_q <= '0;
        end else if (acc) begin
            bank_q <= rev[0];
            addr_q <= {1'b0, rev[LOG2N-1:1]};
            data_q <= {re_s, im_s};
        end
    end

    // Pulse registers hold while disabled and only show on an enabled cycle,
    // so a stalled write/start/err is delayed rather than lost or repeated.
    assign o_wr_en   = (wr_q && i_en) ? (bank_q ? 2'b10 : 2'b01) : 2'b00;
    assign o_wr_addr = addr_q;
    assign o_wr_data = data_q;
    assign o_start   = start_q && i_en;
    assign o_err     = err_q && i_en;
    assign o_busy    = (state != ST_IDLE);

endmodule
